// File: rtl/dsp_dot_accum_if.sv
// Handshake bundle for dsp_dot_accum: upstream tag/credit side plus the
// downstream valid/ready group-result stream.
interface dsp_dot_accum_if #(
    parameter int ACC_WIDTH = 80,
    parameter int CNT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_first;
    logic                        in_last;
    logic                        in_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0]        out_count;
    logic                        out_ovf;

    // Environment side: drives beat tags and consumes finished groups.
    modport master (
        output in_valid, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_first, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/dsp_dot_accum.sv
// Group accumulator behind the non-stallable DSP dot-product chain.
// Beat tags ride a delay line matched to the chain latency, aligned results
// are summed with saturation, and finished groups land in a FWFT FIFO.
// Upstream is throttled by credits so the FIFO can never overflow.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no open group; next valid beat starts one
// ACCUM | group open; beats add into acc until one carries last
module dsp_dot_accum #(
    parameter int IN_WIDTH    = 64,
    parameter int ACC_WIDTH   = 80,
    parameter int MAC_LATENCY = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dsp_dot_accum_if.slave             bus,
    input  logic signed [IN_WIDTH-1:0] mac_result,
    output logic                       err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {IDLE, ACCUM} state_t;

    // tag bit order: {valid, first, last}
    logic [2:0] tag_q [MAC_LATENCY];
    logic [2:0] tag_d [MAC_LATENCY];

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        ovf_q, ovf_d;
    logic                        err_q, err_d;

    logic [CW-1:0]    fifo_count_q, fifo_count_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic signed [ACC_WIDTH-1:0] mem_sum_q [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0]        mem_cnt_q [FIFO_DEPTH];
    logic                        mem_ovf_q [FIFO_DEPTH];

    logic                        in_ready;
    logic                        accept;
    logic                        accept_last;
    logic                        d_valid, d_first, d_last;
    logic signed [ACC_WIDTH-1:0] mac_ext;
    logic [ACC_WIDTH:0]          sum_wide;
    logic                        sat_hit;
    logic signed [ACC_WIDTH-1:0] sat_sum;
    logic [CNT_WIDTH-1:0]        cnt_inc;
    logic                        push;
    logic                        pop;
    logic                        fifo_nonempty;
    logic [CW:0]                 credit_used;

    assign credit_used = {1'b0, fifo_count_q} + {1'b0, inflight_q};
    assign in_ready    = credit_used < (CW+1)'(FIFO_DEPTH);
    assign accept      = bus.in_valid && in_ready;
    assign accept_last = accept && bus.in_last;

    assign d_valid = tag_q[MAC_LATENCY-1][2];
    assign d_first = tag_q[MAC_LATENCY-1][1];
    assign d_last  = tag_q[MAC_LATENCY-1][0];

    // Signed size cast sign-extends the chain result to the accumulator width.
    assign mac_ext  = ACC_WIDTH'(mac_result);
    assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {mac_ext[ACC_WIDTH-1], mac_ext};
    assign sat_hit  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    assign sat_sum  = sat_hit ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                              : sum_wide[ACC_WIDTH-1:0];
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    // Tag delay line: rejected beats enter as all-zero so their results are dropped.
    always_comb begin
        tag_d[0] = {accept, accept && bus.in_first, accept_last};
        for (int i = 1; i < MAC_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Group FSM and accumulator next-state; a group closes on any aligned last.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        push    = 1'b0;
        if (d_valid) begin
            if ((state_q == IDLE && !d_first) || (state_q == ACCUM && d_first)) begin
                err_d = 1'b1;
            end
            // A stray beat in IDLE opens a group; a new first in ACCUM drops the partial sum.
            if (d_first || state_q == IDLE) begin
                acc_d = mac_ext;
                cnt_d = CNT_ONE;
                ovf_d = 1'b0;
            end else begin
                acc_d = sat_sum;
                cnt_d = cnt_inc;
                ovf_d = ovf_q | sat_hit;
            end
            if (d_last) begin
                push    = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    assign fifo_nonempty = fifo_count_q != '0;
    assign pop           = fifo_nonempty && bus.out_ready;

    // FIFO pointers and credit bookkeeping; coincident events cancel naturally.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        inflight_d   = inflight_q + CW'(accept_last) - CW'(push);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAC_LATENCY; i++) begin
                tag_q[i] <= 3'b000;
            end
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            fifo_count_q <= '0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            tag_q        <= tag_d;
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are masked by the occupancy count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum_q[wr_ptr_q] <= acc_d;
            mem_cnt_q[wr_ptr_q] <= cnt_d;
            mem_ovf_q[wr_ptr_q] <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = fifo_nonempty;
    assign bus.out_sum   = fifo_nonempty ? mem_sum_q[rd_ptr_q] : '0;
    assign bus.out_count = fifo_nonempty ? mem_cnt_q[rd_ptr_q] : '0;
    assign bus.out_ovf   = fifo_nonempty && mem_ovf_q[rd_ptr_q];
    assign err           = err_q;

    // The credit rule guarantees every push finds a free FIFO slot.
    a_no_fifo_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_count_q == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_dsp_dot_accum.sv
// Directed bench for dsp_dot_accum with a 64-bit accumulator; the chain is
// modelled as a plain 6-stage delay of the per-beat result value.
module tb_dsp_dot_accum;
    localparam int LAT = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [63:0] beat_val = '0;
    logic signed [63:0] res_pipe [LAT];
    logic signed [63:0] mac_result;
    logic err;
    int tests = 0;
    int fails = 0;

    dsp_dot_accum_if #(.ACC_WIDTH(64), .CNT_WIDTH(16)) bus ();

    dsp_dot_accum #(
        .IN_WIDTH(64), .ACC_WIDTH(64), .MAC_LATENCY(LAT),
        .FIFO_DEPTH(4), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .mac_result(mac_result), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) res_pipe[i] <= res_pipe[i-1];
        res_pipe[0] <= beat_val;
    end
    assign mac_result = res_pipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold one beat (or idle) for one full cycle, negedge to negedge.
    task automatic drive(input logic v, input logic f, input logic l, input logic signed [63:0] val);
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_last  = l;
        beat_val     = val;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 64'sd999);
    endtask

    // Returns how many cycles after the last beat out_valid appeared (30 = timeout).
    task automatic wait_valid(output int n);
        n = 1;
        while (!bus.out_valid && n < 30) begin
            idle(1);
            n++;
        end
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        idle(1);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_group(input string tag, input logic [63:0] sum,
                               input logic [63:0] cnt, input logic [63:0] ovf);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_sum"}, bus.out_sum, sum);
        check({tag, "_count"}, 64'(bus.out_count), cnt);
        check({tag, "_ovf"}, 64'(bus.out_ovf), ovf);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_sum"}, bus.out_sum, 64'd0);
        check({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
        check({tag, "_out_ovf"}, 64'(bus.out_ovf), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int accepted;
        int seen;
        logic signed [63:0] bp_vals [4];

        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle(LAT + 2);

        // Four-beat group: 10 - 3 + 7 + 100 = 114, visible 7 cycles after last.
        drive(1, 1, 0, 64'sd10);
        drive(1, 0, 0, -64'sd3);
        drive(1, 0, 0, 64'sd7);
        drive(1, 0, 1, 64'sd100);
        wait_valid(n);
        check("g4_latency", 64'(n), 64'd7);
        check_group("g4", 64'sd114, 64'd4, 64'd0);
        pop_one();
        check("g4_drained", 64'(bus.out_valid), 64'd0);

        // Single-beat group.
        drive(1, 1, 1, -64'sd5);
        wait_valid(n);
        check("g1_latency", 64'(n), 64'd7);
        check_group("g1", -64'sd5, 64'd1, 64'd0);
        pop_one();

        // Positive saturation, then a clean group clears ovf.
        drive(1, 1, 0, 64'sh4000_0000_0000_0000);
        drive(1, 0, 1, 64'sh4000_0000_0000_0000);
        wait_valid(n);
        check_group("satp", 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        pop_one();
        drive(1, 1, 0, 64'sd1);
        drive(1, 0, 1, 64'sd2);
        wait_valid(n);
        check_group("after_sat", 64'sd3, 64'd2, 64'd0);
        pop_one();

        // Reaching exactly the minimum is not saturation; going past it is.
        drive(1, 1, 0, 64'shC000_0000_0000_0000);
        drive(1, 0, 0, 64'shC000_0000_0000_0000);
        drive(1, 0, 1, -64'sd1);
        wait_valid(n);
        check_group("satn", 64'h8000_0000_0000_0000, 64'd3, 64'd1);
        pop_one();
        check("err_clean", 64'(err), 64'd0);

        // Backpressure: only four single-beat groups get credit.
        bp_vals[0] = 64'sd11;
        bp_vals[1] = 64'sd22;
        bp_vals[2] = 64'sd33;
        bp_vals[3] = 64'sd44;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_first = 1'b1;
            bus.in_last  = 1'b1;
            beat_val     = 64'(11 * (i + 1));
            check($sformatf("bp_ready_%0d", i), 64'(bus.in_ready), (i < 4) ? 64'd1 : 64'd0);
            if (bus.in_ready) accepted++;
            @(negedge clk);
        end
        check("bp_accepted", 64'(accepted), 64'd4);
        idle(8);
        check("bp_full_ready", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check_group($sformatf("bp%0d", k), bp_vals[k], 64'd1, 64'd0);
            pop_one();
            if (k == 0) check("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
        end
        check("bp_empty", 64'(bus.out_valid), 64'd0);

        // Beat without first in IDLE: treated as first, err raised.
        drive(1, 0, 0, 64'sd5);
        drive(1, 0, 1, 64'sd6);
        wait_valid(n);
        check_group("nofirst", 64'sd11, 64'd2, 64'd0);
        check("nofirst_err", 64'(err), 64'd1);
        pop_one();

        // New first mid-group: partial 7+8 dropped, only 100+1+2 emitted.
        drive(1, 1, 0, 64'sd7);
        drive(1, 0, 0, 64'sd8);
        drive(1, 1, 0, 64'sd100);
        drive(1, 0, 0, 64'sd1);
        drive(1, 0, 1, 64'sd2);
        wait_valid(n);
        check_group("restart", 64'sd103, 64'd3, 64'd0);
        pop_one();
        idle(10);
        check("restart_single_out", 64'(bus.out_valid), 64'd0);

        // Reset mid-group with a stored group pending in the FIFO.
        drive(1, 1, 1, 64'sd77);
        wait_valid(n);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        drive(1, 1, 0, 64'sd1);
        drive(1, 0, 0, 64'sd2);
        drive(1, 0, 0, 64'sd3);
        rst_n = 1'b0;
        drive(1, 0, 0, 64'sd4);
        check_reset_outputs("midrst");
        drive(1, 0, 1, 64'sd5);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        drive(1, 1, 0, 64'sd4);
        drive(1, 0, 1, 64'sd5);
        wait_valid(n);
        check("post_rst_latency", 64'(n), 64'd7);
        check_group("post_rst", 64'sd9, 64'd2, 64'd0);
        check("post_rst_err", 64'(err), 64'd0);
        pop_one();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dsp_dot_accum.md
# dsp_dot_accum

Downstream consumer of the 27x27 systolic dot-product chain. It tracks which chain outputs are valid by delaying the input-side tags (valid/first/last) by the chain latency. It accumulates successive chain results into one wide sum per group and delivers each finished group through a valid/ready output FIFO. Because the DSP chain cannot stall, the block also issues credit-based `in_ready` back to the upstream source.

## Interface
- `IN_WIDTH`, 64: width of the signed chain result.
- `ACC_WIDTH`, 80: width of the signed accumulator and output sum; must be >= `IN_WIDTH`.
- `MAC_LATENCY`, 6: cycles from `ax`/`ay` entering the chain to the matching `mac_result`; must be >= 1.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, >= 2.
- `CNT_WIDTH`, 16: width of the beat counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream beat valid; sampled in the same cycle the upstream drives `ax`/`ay` into the chain.
- `in_first` in 1: beat starts a group.
- `in_last` in 1: beat ends a group.
- `in_ready` out 1: the block accepts tags this cycle.
- `mac_result` in `IN_WIDTH`, signed: chain output (`result`).
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts the head.
- `out_sum` out `ACC_WIDTH`, signed: group sum.
- `out_count` out `CNT_WIDTH`: beats in the group; saturates at all-ones.
- `out_ovf` out 1: the group sum saturated.
- `err` out 1: sticky protocol error, cleared only by reset.

## Operation
- **Acceptance.** A beat is accepted when `in_valid && in_ready`. Beats that are not accepted enter the tag delay line as invalid, so their chain outputs are ignored.
- **Tag delay line.** A `MAC_LATENCY`-deep shift register of {valid, first, last}. Its output (`d_valid`, `d_first`, `d_last`) is aligned with `mac_result`.
- **Sign extension.** `mac_result` is sign-extended to `ACC_WIDTH` before the add.
- **FSM states.**
  - IDLE → ACCUM on `d_valid && d_first && !d_last`.
  - ACCUM → IDLE on `d_valid && d_last`.
  - IDLE stays IDLE on `d_valid && d_first && d_last` (single-beat group, pushed immediately).
- **On `d_valid` with first:** acc = ext(`mac_result`), cnt = 1, ovf = 0.
- **On `d_valid` otherwise:** acc = sat(acc + ext(`mac_result`)), cnt = sat(cnt + 1), and ovf |= saturation occurred.
- **Saturation** clamps to the signed `ACC_WIDTH` max/min.
- **On `d_last`:** push {acc_next, cnt_next, ovf_next} into the FIFO, where `_next` is the value including the current beat.
- **Protocol errors.** Each of the following sets `err`:
  - `d_valid` without first while in IDLE: the beat is treated as first.
  - `d_first` while in ACCUM: the partial group is discarded and accumulation restarts.
- **Credit.** `inflight` counts accepted `in_last` beats not yet pushed. `in_ready = (fifo_count + inflight) < FIFO_DEPTH`. It is combinational from registers only and does not depend on `in_valid`.
- **Credit bookkeeping when events coincide.**
  - Accept-last and push in the same cycle: `inflight` is unchanged and `fifo_count` increments.
  - Push and pop in the same cycle: `fifo_count` is unchanged.
- **FIFO overflow.** A push into a full FIFO cannot occur under the credit rule; an assertion must check this.
- **FIFO outputs.** The FIFO is first-word-fall-through. `out_sum`, `out_count` and `out_ovf` are stable while `out_valid && !out_ready`.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_sum` = 0, `out_count` = 0, `out_ovf` = 0, `err` = 0.
  - `in_ready` = 1.
  - Delay line cleared, FSM in IDLE, `inflight` = 0, FIFO empty.
- **Reset mid-operation** discards all in-flight tags and stored groups. Chain outputs that arrive after reset is released are ignored, because their tags were cleared.
- **Accumulator update:** a beat accepted at cycle t reaches the accumulator at the edge ending cycle t+`MAC_LATENCY`.
- **Output latency:** an accepted `in_last` at cycle t gives `out_valid` = 1 at t+`MAC_LATENCY`+1 when the FIFO is empty.
- **Throughput:** one beat per cycle sustained, as long as the downstream drains at least one group per group length.
- **`in_ready` deassertion:** drops in the cycle after the credit-exhausting `in_last` is accepted. It rises in the cycle after the pop that frees a credit.

## Test plan
- **Single 4-beat group.** `MAC_LATENCY` = 6, `mac_result` values 10, -3, 7, 100 on the aligned cycles → one output: `out_sum` = 114, `out_count` = 4, `out_ovf` = 0. `out_valid` rises at t_last+7.
- **Single-beat group.** first = last = 1, `mac_result` = -5 → `out_sum` = -5, `out_count` = 1. The FSM stays in IDLE.
- **Saturation.** `ACC_WIDTH` = `IN_WIDTH` = 64, two beats of 2^62 → `out_sum` = 2^63-1, `out_ovf` = 1. The next group reports `out_ovf` = 0.
- **Backpressure.** `FIFO_DEPTH` = 4, `out_ready` = 0, back-to-back single-beat groups offered every cycle → exactly 4 accepted, and `in_ready` = 0 from the cycle after the 4th. After `out_ready` = 1 for one pop, `in_ready` returns to 1 in the next cycle. FIFO order and values are preserved.
- **Protocol errors.**
  - Beat without first in IDLE → `err` = 1 and the group sums correctly from that beat.
  - New first mid-group after 2 beats → the partial sum is dropped and only the new group is emitted.
- **Reset mid-group.** Assert `rst_n` low after 3 beats of a 5-beat group → all outputs return to reset values. The trailing chain results produce no output, and the next clean group is correct.
